// File: rtl/gpio_irq_pkg.sv
// gpio_irq_pkg: shared FSM state type, channel limit and channel-index width helper.
// No ports. Imported by lowest_set_encoder and gpio_irq_controller.
package gpio_irq_pkg;
    localparam int GPIO_IRQ_MAX_WIDTH = 32;
    typedef enum logic {IRQ_IDLE, IRQ_BUSY} irq_state_e;
    function automatic int gpio_id_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction
endpackage

// File: rtl/lowest_set_encoder.sv
// lowest_set_encoder: combinational priority encoder, lowest set index wins.
// Ports: vec_i (WIDTH-bit request vector), valid_o (any bit set), index_o (lowest set index, 0 when none).
module lowest_set_encoder import gpio_irq_pkg::*; #(
    parameter int WIDTH    = 16,
    parameter int ID_WIDTH = gpio_id_width(WIDTH)
) (
    input  logic [WIDTH-1:0]    vec_i,
    output logic                valid_o,
    output logic [ID_WIDTH-1:0] index_o
);
    always_comb begin
        valid_o = |vec_i;
        index_o = '0;
        // Scanning downward lets the lowest set bit be the last write.
        for (int i = WIDTH - 1; i >= 0; i--)
            if (vec_i[i]) index_o = ID_WIDTH'(i);
    end
endmodule

// File: rtl/gpio_irq_controller.sv
// gpio_irq_controller: pending register, claim/complete FSM and a single prioritised interrupt line.
// Ports: clk_i, reset_i (sync, active-high); edges_i/enable_i per-channel edge flags and enables;
// clear_valid_i/clear_mask_i write-1-to-clear; claim_valid_i/complete_valid_i handshake;
// pending_o, irq_o, irq_id_o, active_id_o, busy_o all registered.
module gpio_irq_controller import gpio_irq_pkg::*; #(
    parameter int WIDTH    = 16,
    parameter int ID_WIDTH = gpio_id_width(WIDTH)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [WIDTH-1:0]    edges_i,
    input  logic [WIDTH-1:0]    enable_i,
    input  logic                clear_valid_i,
    input  logic [WIDTH-1:0]    clear_mask_i,
    input  logic                claim_valid_i,
    input  logic                complete_valid_i,
    output logic [WIDTH-1:0]    pending_o,
    output logic                irq_o,
    output logic [ID_WIDTH-1:0] irq_id_o,
    output logic [ID_WIDTH-1:0] active_id_o,
    output logic                busy_o
);
    irq_state_e          state_q, state_d;
    logic [WIDTH-1:0]    pending_q, pending_d, clr_d, masked_d;
    logic                irq_q, claim_fire, enc_valid, irq_d;
    logic [ID_WIDTH-1:0] irq_id_q, active_id_q, enc_index;
    logic                busy_q;

    always_comb begin
        // irq_q is only ever high in IDLE, so it alone qualifies the claim.
        claim_fire = claim_valid_i && irq_q;
        clr_d      = (clear_valid_i ? clear_mask_i : '0) | (claim_fire ? WIDTH'(1) << irq_id_q : '0);
        // New edges are OR-ed after the clear so a same-cycle set wins.
        pending_d  = (pending_q & ~clr_d) | (edges_i & enable_i);
        masked_d   = pending_d & enable_i;
        state_d    = (state_q == IRQ_IDLE) ? (claim_fire ? IRQ_BUSY : IRQ_IDLE)
                                           : (complete_valid_i ? IRQ_IDLE : IRQ_BUSY);
        irq_d      = (state_d == IRQ_IDLE) && enc_valid;
    end

    lowest_set_encoder #(.WIDTH(WIDTH), .ID_WIDTH(ID_WIDTH)) u_enc (
        .vec_i   (masked_d),
        .valid_o (enc_valid),
        .index_o (enc_index)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IRQ_IDLE;
            pending_q   <= '0;
            irq_q       <= 1'b0;
            irq_id_q    <= '0;
            active_id_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            irq_q       <= irq_d;
            irq_id_q    <= irq_d ? enc_index : '0;
            active_id_q <= claim_fire ? irq_id_q : active_id_q;
            busy_q      <= state_d == IRQ_BUSY;
        end
    end

    assign pending_o   = pending_q;
    assign irq_o       = irq_q;
    assign irq_id_o    = irq_id_q;
    assign active_id_o = active_id_q;
    assign busy_o      = busy_q;
endmodule

// File: tb/tb_gpio_irq_controller.sv
// tb_gpio_irq_controller: scoreboard bench for gpio_irq_controller with a behavioural reference model.
// No ports.
module tb_gpio_irq_controller;
    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] pend;
        logic         irq;
        logic [3:0]   id;
        logic [3:0]   act;
        logic         busy;
    } exp_t;

    logic         clk_i = 0, reset_i;
    logic [W-1:0] edges_i, enable_i, clear_mask_i;
    logic         clear_valid_i, claim_valid_i, complete_valid_i;
    logic [W-1:0] pending_o;
    logic         irq_o, busy_o;
    logic [3:0]   irq_id_o, active_id_o;

    int total = 0, bad = 0;
    exp_t sb[$];

    logic [W-1:0] m_pend;
    logic         m_irq, m_busy;
    logic [3:0]   m_id, m_act;

    gpio_irq_controller #(.WIDTH(W)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .edges_i(edges_i), .enable_i(enable_i),
        .clear_valid_i(clear_valid_i), .clear_mask_i(clear_mask_i),
        .claim_valid_i(claim_valid_i), .complete_valid_i(complete_valid_i),
        .pending_o(pending_o), .irq_o(irq_o), .irq_id_o(irq_id_o),
        .active_id_o(active_id_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference model: advance one cycle from the spec's rules and queue the result.
    task automatic model(input logic rst);
        logic         fire;
        logic [W-1:0] clr, np, mk;
        logic         nb, nirq;
        logic [3:0]   nid, na;
        if (rst) begin
            np = '0; nb = 0; na = 0; nirq = 0; nid = 0;
        end else begin
            fire = !m_busy && claim_valid_i && m_irq;
            clr  = clear_valid_i ? clear_mask_i : '0;
            if (fire) clr[m_id] = 1'b1;
            np   = (m_pend & ~clr) | (edges_i & enable_i);
            nb   = m_busy ? !complete_valid_i : fire;
            na   = fire ? m_id : m_act;
            mk   = np & enable_i;
            nirq = !nb && (mk != 0);
            nid  = 0;
            if (nirq)
                for (int i = 0; i < W; i++)
                    if (mk[i]) begin nid = 4'(i); break; end
        end
        m_pend = np; m_busy = nb; m_act = na; m_irq = nirq; m_id = nid;
        sb.push_back('{np, nirq, nid, na, nb});
    endtask

    task automatic step(input logic [W-1:0] e, input logic [W-1:0] en,
                        input logic cv = 0, input logic [W-1:0] cm = '0,
                        input logic cl = 0, input logic co = 0, input logic rst = 0);
        exp_t x;
        edges_i = e; enable_i = en; clear_valid_i = cv; clear_mask_i = cm;
        claim_valid_i = cl; complete_valid_i = co; reset_i = rst;
        model(rst);
        @(posedge clk_i);
        #1;
        x = sb.pop_front();
        chk("pending",   32'(pending_o),   32'(x.pend));
        chk("irq",       32'(irq_o),       32'(x.irq));
        chk("irq_id",    32'(irq_id_o),    32'(x.id));
        chk("active_id", 32'(active_id_o), 32'(x.act));
        chk("busy",      32'(busy_o),      32'(x.busy));
    endtask

    localparam logic [W-1:0] ALL = 16'hFFFF;

    initial begin
        m_pend = 'x; m_irq = 'x; m_busy = 'x; m_id = 'x; m_act = 'x;
        step(0, 0, .rst(1));
        step(0, 0, .rst(1));
        chk("rst_all", {pending_o, 3'b0, irq_o, irq_id_o, active_id_o, 3'b0, busy_o}, 0);
        repeat (10) step(0, ALL);
        chk("idle_irq", 32'(irq_o), 0);

        // priority and claim/complete
        step(16'h0090, ALL);
        chk("prio_pend", 32'(pending_o), 32'h0090);
        chk("prio_id", 32'(irq_id_o), 4);
        step(0, ALL, .cl(1));
        chk("claim_act", 32'(active_id_o), 4);
        chk("claim_pend", 32'(pending_o), 32'h0080);
        chk("claim_irq", 32'(irq_o), 0);
        step(16'h0001, ALL);
        step(0, ALL, .cl(1));
        step(0, ALL, .co(1));
        chk("cmpl_irq", 32'(irq_o), 1);
        chk("cmpl_id", 32'(irq_id_o), 0);
        step(0, ALL, .cl(1));
        step(0, ALL, .co(1));
        chk("next_id", 32'(irq_id_o), 7);
        step(0, ALL, .cl(1));
        step(0, ALL, .co(1));

        // masking
        step(16'h0008, 0);
        chk("mask_drop", 32'(pending_o), 0);
        step(16'h0020, ALL);
        step(0, 16'hFFDF);
        chk("mask_irq", 32'(irq_o), 0);
        chk("mask_keep", 32'(pending_o), 32'h0020);
        step(0, ALL);
        chk("unmask_id", 32'(irq_id_o), 5);
        step(0, ALL, .cl(1));
        step(0, ALL, .co(1));

        // edge and claim on the same channel
        step(16'h0004, ALL);
        step(16'h0004, ALL, .cl(1));
        chk("sim_pend2", 32'(pending_o[2]), 1);
        chk("sim_busy", 32'(busy_o), 1);
        step(0, ALL, .co(1));
        chk("sim_id2", 32'(irq_id_o), 2);
        step(0, ALL, .cl(1));
        step(0, ALL, .co(1));

        // edge and clear on the same channel
        step(16'h0004, ALL, .cv(1), .cm(16'h0004));
        chk("setwins", 32'(pending_o[2]), 1);
        step(0, ALL, .cv(1), .cm(ALL));

        // ignored handshakes and clear-all
        step(0, ALL, .cl(1));
        step(0, ALL, .co(1));
        step(16'h0301, ALL);
        step(0, ALL, .cv(1), .cm(ALL));
        chk("clrall", 32'(pending_o), 0);

        // reset while busy with 0x0005 pending
        step(16'h0002, ALL);
        step(16'h0005, ALL, .cl(1));
        chk("pre_rst", 32'(pending_o), 32'h0005);
        step(0, ALL, .rst(1));
        chk("busy_rst", {pending_o, 3'b0, irq_o, irq_id_o, active_id_o, 3'b0, busy_o}, 0);

        // random traffic against the model
        repeat (300) begin
            logic [W-1:0] e, en;
            e  = ($urandom_range(0, 3) == 0) ? W'($urandom) : '0;
            en = ($urandom_range(0, 7) == 0) ? W'($urandom) : ALL;
            step(e, en, $urandom_range(0, 9) == 0, W'($urandom),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 99) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
